// File: rtl/axi_redirect_pkg.sv
// Shared types and helpers for the AXI address-redirect controller.
// Defines the FSM state encoding, the latched request record and the legality rule.
package axi_redirect_pkg;

    localparam int unsigned DRAIN_TIMEOUT_DEFAULT = 32'd1024;
    localparam int unsigned REQ_IDX_W             = 32'd8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HOLD   = 3'd1,
        DRAIN  = 3'd2,
        COMMIT = 3'd3,
        RESP   = 3'd4
    } state_e;

    typedef struct packed {
        logic                 clear;
        logic [REQ_IDX_W-1:0] source;
        logic [REQ_IDX_W-1:0] target;
    } redirect_req_t;

    // A clear is always legal; a swap needs two distinct, in-range port indices.
    function automatic logic req_is_legal(input redirect_req_t r, input int unsigned n_ports);
        return r.clear ||
               ((r.source != r.target) &&
                (32'(r.source) < n_ports) &&
                (32'(r.target) < n_ports));
    endfunction

endpackage

// File: rtl/axi_redirect_drain_timer.sv
// Drain-phase cycle counter: synchronous clear, count enable, and an expire flag
// raised while the count equals DRAIN_TIMEOUT-1.
module axi_redirect_drain_timer #(
    parameter int unsigned DRAIN_TIMEOUT = 32'd1024,
    parameter int unsigned CNT_WIDTH     = 32'd11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Next count: clear has priority over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CNT_WIDTH'(DRAIN_TIMEOUT - 32'd1));

endmodule

// File: rtl/axi_redirect_ctrl.sv
// Run-time redirect sequencer: accept, stall decoders, drain, commit atomically, respond.
// Optional feature macro AXI_REDIRECT_LOCK_EN adds a sticky lock set by a successful swap.
module axi_redirect_ctrl
    import axi_redirect_pkg::*;
#(
    parameter int unsigned N_INIT_PORT   = 32'd8,
    parameter int unsigned LOG_N_INIT    = 32'd3,
    parameter int unsigned DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_WIDTH     = 32'd11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_clear_i,
    input  logic [LOG_N_INIT-1:0]  req_source_i,
    input  logic [LOG_N_INIT-1:0]  req_target_i,
    input  logic [N_INIT_PORT-1:0] outstanding_trans_i,
    input  logic [N_INIT_PORT-1:0] addr_busy_i,
    output logic                   decode_hold_o,
    output logic [LOG_N_INIT-1:0]  source_r_o,
    output logic [LOG_N_INIT-1:0]  target_r_o,
    output logic                   redirect_valid_r_o,
    output logic                   rsp_valid_o,
    output logic                   rsp_err_o
);

    state_e                state_q, state_d;
    redirect_req_t         req_q, req_d;
    logic [LOG_N_INIT-1:0] source_q, source_d;
    logic [LOG_N_INIT-1:0] target_q, target_d;
    logic                  valid_q, valid_d;
    logic                  hold_q, hold_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  ready_q, ready_d;

    redirect_req_t in_req_s;
    logic          legal_s;
    logic          locked_s;
    logic          quiescent_s;
    logic          tmr_clr_s;
    logic          tmr_en_s;
    logic          tmr_expire_s;

    assign in_req_s.clear  = req_clear_i;
    assign in_req_s.source = REQ_IDX_W'(req_source_i);
    assign in_req_s.target = REQ_IDX_W'(req_target_i);
    assign legal_s         = req_is_legal(in_req_s, N_INIT_PORT);
    assign quiescent_s     = ~(|outstanding_trans_i) & ~(|addr_busy_i);

`ifdef AXI_REDIRECT_LOCK_EN
    logic lock_q, lock_d;
    assign locked_s = lock_q;

    // Sticky lock: only rst_n releases it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    assign locked_s = 1'b0;
`endif

    axi_redirect_drain_timer #(
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_drain_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmr_clr_s),
        .en_i     (tmr_en_s),
        .expire_o (tmr_expire_s)
    );

    // Next-state and next-output logic; output registers are loaded for the state being entered.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        source_d    = source_q;
        target_d    = target_q;
        valid_d     = valid_q;
        hold_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        tmr_clr_s   = 1'b0;
        tmr_en_s    = 1'b0;
`ifdef AXI_REDIRECT_LOCK_EN
        lock_d      = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    req_d = in_req_s;
                    if (locked_s || !legal_s) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = HOLD;
                        hold_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                state_d   = DRAIN;
                hold_d    = 1'b1;
                tmr_clr_s = 1'b1;
            end
            DRAIN: begin
                tmr_en_s = 1'b1;
                // Quiescence takes priority over a simultaneous timeout.
                if (quiescent_s) begin
                    state_d = COMMIT;
                    hold_d  = 1'b1;
                end else if (tmr_expire_s) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    hold_d = 1'b1;
                end
            end
            COMMIT: begin
                if (req_q.clear) begin
                    valid_d = 1'b0;
                end else begin
                    source_d = LOG_N_INIT'(req_q.source);
                    target_d = LOG_N_INIT'(req_q.target);
                    valid_d  = 1'b1;
`ifdef AXI_REDIRECT_LOCK_EN
                    lock_d   = 1'b1;
`endif
                end
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            source_q    <= '0;
            target_q    <= '0;
            valid_q     <= 1'b0;
            hold_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            source_q    <= source_d;
            target_q    <= target_d;
            valid_q     <= valid_d;
            hold_q      <= hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            ready_q     <= ready_d;
        end
    end

    assign req_ready_o        = ready_q;
    assign decode_hold_o      = hold_q;
    assign source_r_o         = source_q;
    assign target_r_o         = target_q;
    assign redirect_valid_r_o = valid_q;
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_err_o          = rsp_err_q;

endmodule

// File: tb/tb_axi_redirect_ctrl.sv
// Scoreboard bench for axi_redirect_ctrl: a driver pushes expected responses computed
// from a transaction-level model; an independent monitor pops and compares on rsp_valid_o.
module tb_axi_redirect_ctrl;

    localparam int N  = 6;
    localparam int LW = 3;
    localparam int T  = 16;
    localparam int CW = 5;

    logic          clk;
    logic          rst_n;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_clear_i;
    logic [LW-1:0] req_source_i;
    logic [LW-1:0] req_target_i;
    logic [N-1:0]  outstanding_trans_i;
    logic [N-1:0]  addr_busy_i;
    logic          decode_hold_o;
    logic [LW-1:0] source_r_o;
    logic [LW-1:0] target_r_o;
    logic          redirect_valid_r_o;
    logic          rsp_valid_o;
    logic          rsp_err_o;

    axi_redirect_ctrl #(
        .N_INIT_PORT   (N),
        .LOG_N_INIT    (LW),
        .DRAIN_TIMEOUT (T),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_clear_i         (req_clear_i),
        .req_source_i        (req_source_i),
        .req_target_i        (req_target_i),
        .outstanding_trans_i (outstanding_trans_i),
        .addr_busy_i         (addr_busy_i),
        .decode_hold_o       (decode_hold_o),
        .source_r_o          (source_r_o),
        .target_r_o          (target_r_o),
        .redirect_valid_r_o  (redirect_valid_r_o),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_err_o           (rsp_err_o)
    );

    typedef struct {
        bit err;
        int src;
        int tgt;
        bit vld;
        int rsp_cyc;
        int holds;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    int ref_src  = 0;
    int ref_tgt  = 0;
    bit ref_vld  = 1'b0;
    bit ref_lock = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts hold cycles and scores each response against the queue.
    initial begin
        int   hold_seen;
        exp_t e;
        hold_seen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_seen = 0;
            end else begin
                if (decode_hold_o) begin
                    hold_seen++;
                    check("ready_low_while_hold", int'(req_ready_o), 0);
                end
                if (rsp_valid_o) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_err", int'(rsp_err_o), int'(e.err));
                        check("rsp_latency", cyc, e.rsp_cyc);
                        check("hold_cycles", hold_seen, e.holds);
                        check("hold_off_at_rsp", int'(decode_hold_o), 0);
                        check("source_r", int'(source_r_o), e.src);
                        check("target_r", int'(target_r_o), e.tgt);
                        check("redirect_valid_r", int'(redirect_valid_r_o), int'(e.vld));
                    end
                    hold_seen = 0;
                end
            end
        end
    end

    task automatic idle_inputs();
        req_valid_i         = 1'b0;
        req_clear_i         = 1'b0;
        req_source_i        = '0;
        req_target_i        = '0;
        outstanding_trans_i = '0;
        addr_busy_i         = '0;
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", int'(req_ready_o), 1);
        check("rst_hold", int'(decode_hold_o), 0);
        check("rst_source", int'(source_r_o), 0);
        check("rst_target", int'(target_r_o), 0);
        check("rst_valid", int'(redirect_valid_r_o), 0);
        check("rst_rsp_valid", int'(rsp_valid_o), 0);
        check("rst_rsp_err", int'(rsp_err_o), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        sb.delete();
        ref_src  = 0;
        ref_tgt  = 0;
        ref_vld  = 1'b0;
        ref_lock = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();
    endtask

    task automatic wait_scoreboard_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("rsp_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // b = number of drain cycles the node stays busy before going quiet.
    task automatic do_req(input bit clr, input int src, input int tgt, input int b,
                          input logic [N-1:0] ot, input logic [N-1:0] ab);
        exp_t e;
        bit   legal;
        int   acc;
        @(negedge clk);
        check("ready_idle", int'(req_ready_o), 1);
        if (b > 0 && (ot | ab) == '0) ot = 1;
        req_valid_i  = 1'b1;
        req_clear_i  = clr;
        req_source_i = src[LW-1:0];
        req_target_i = tgt[LW-1:0];
        outstanding_trans_i = (b > 0) ? ot : '0;
        addr_busy_i         = (b > 0) ? ab : '0;
        acc   = cyc;
        legal = clr || (src != tgt && src < N && tgt < N);
        if (!legal || ref_lock) begin
            e.err = 1'b1; e.rsp_cyc = acc + 1; e.holds = 0;
        end else if (b < T) begin
            e.err = 1'b0; e.rsp_cyc = acc + 4 + b; e.holds = b + 3;
            if (clr) begin
                ref_vld = 1'b0;
            end else begin
                ref_src = src; ref_tgt = tgt; ref_vld = 1'b1;
`ifdef AXI_REDIRECT_LOCK_EN
                ref_lock = 1'b1;
`endif
            end
        end else begin
            e.err = 1'b1; e.rsp_cyc = acc + 2 + T; e.holds = T + 1;
        end
        e.src = ref_src; e.tgt = ref_tgt; e.vld = ref_vld;
        sb.push_back(e);
        for (int k = 1; k <= b + 2; k++) begin
            @(negedge clk);
            if (k == 1) req_valid_i = 1'b0;
            if (k == b + 2) begin
                outstanding_trans_i = '0;
                addr_busy_i         = '0;
            end
        end
        wait_scoreboard_empty();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, sel;
        logic [N-1:0] pat;
        rst_n = 1'b0;
        idle_inputs();
        apply_reset();

        do_req(1'b0, 2, 5, 0, '0, '0);
        do_req(1'b0, 3, 1, 12, 6'b001000, '0);
        do_req(1'b0, 0, 4, 40, 6'b000001, '0);
        do_req(1'b0, 4, 4, 0, '0, '0);
        do_req(1'b0, 1, 6, 0, '0, '0);
        do_req(1'b0, 2, 3, T - 1, '0, 6'b100000);
        do_req(1'b0, 2, 3, T, '0, 6'b000100);

        apply_reset();
        do_req(1'b1, 0, 0, 0, '0, '0);
        do_req(1'b0, 1, 4, 0, '0, '0);
        do_req(1'b1, 0, 0, 3, '0, 6'b000010);

        // Reset in the middle of a drain: no partial commit.
        @(negedge clk);
        req_valid_i = 1'b1; req_clear_i = 1'b0;
        req_source_i = 3'd3; req_target_i = 3'd0;
        outstanding_trans_i = 6'b000001;
        @(negedge clk);
        req_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        check("hold_in_drain", int'(decode_hold_o), 1);
        apply_reset();

        do_req(1'b0, 0, 5, 0, '0, '0);
        do_req(1'b1, 0, 0, 0, '0, '0);
        apply_reset();
        do_req(1'b0, 3, 1, 2, 6'b010000, '0);

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      b = $urandom_range(0, 5);
            else if (sel < 9) b = $urandom_range(T - 2, T + 2);
            else              b = 0;
            pat = N'($urandom_range(1, (1 << N) - 1));
            if (i % 50 == 49) apply_reset();
            do_req(($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom_range(0, 7), b,
                   ($urandom_range(0, 1) == 1) ? pat : '0, pat);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_redirect_ctrl.md
Name: axi_redirect_ctrl

Overview:
- Sequences run-time address-redirect updates for the AXI node AW/AR decoders: accepts a (source, target) swap or clear request, stalls new address decodes, drains outstanding transactions, then commits the new redirect atomically.
- Drives the registered source_r/target_r/redirect_valid_r signals consumed by the decoders' swap logic.
- Sits one per AXI node, between the configuration/security master and all address decoders of that node.

Parameters:
- N_INIT_PORT, 8, number of initiator (slave-side) ports whose decoders are controlled
- LOG_N_INIT, 3, width of source/target port index
- DRAIN_TIMEOUT, 1024, max cycles spent draining before the request is aborted
- CNT_WIDTH, 11, timeout counter width; must satisfy 2^CNT_WIDTH > DRAIN_TIMEOUT

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  redirect request valid
- req_ready_o  out  1  request accepted (IDLE only)
- req_clear_i  in  1  1 = remove redirect, 0 = install swap
- req_source_i  in  LOG_N_INIT  port index to redirect from
- req_target_i  in  LOG_N_INIT  port index to redirect to
- outstanding_trans_i  in  N_INIT_PORT  per-port outstanding-transaction flags from the decoders
- addr_busy_i  in  N_INIT_PORT  per-port awvalid/arvalid currently presented
- decode_hold_o  out  1  forces decoders to deassert grant (stall new address acceptance)
- source_r_o  out  LOG_N_INIT  committed redirect source
- target_r_o  out  LOG_N_INIT  committed redirect target
- redirect_valid_r_o  out  1  committed redirect enable
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_err_o  out  1  qualifies rsp_valid_o: 1 = aborted/rejected

Behaviour:
- Reset: state IDLE, decode_hold_o=0, source_r_o=0, target_r_o=0, redirect_valid_r_o=0, rsp_valid_o=0, rsp_err_o=0, counter=0.
- Outputs are registered; decoders see only committed values.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&req_ready_o: latch clear/source/target, then check legality.
  - Illegal if !clear and (source==target, or either index >= N_INIT_PORT). Illegal request -> RESP with err=1; committed registers unchanged.
  - Legal request -> HOLD.
- HOLD (1 cycle): decode_hold_o=1; lets any handshake in the same cycle complete. -> DRAIN; counter cleared.
- DRAIN:
  - decode_hold_o=1; counter increments each cycle.
  - If (|outstanding_trans_i)==0 and (|addr_busy_i)==0 -> COMMIT.
  - Else if counter==DRAIN_TIMEOUT-1 -> RESP with err=1, registers unchanged.
  - Quiescence and timeout in the same cycle: quiescence wins.
- COMMIT (1 cycle):
  - decode_hold_o=1.
  - Clear: redirect_valid_r_o<=0; source/target retain their old values.
  - Swap: source_r_o, target_r_o and redirect_valid_r_o (<=1) update in the same edge.
  - -> RESP with err=0.
- RESP (1 cycle): rsp_valid_o=1, decode_hold_o=0. -> IDLE.
- Latency, legal request on a quiescent node: accept edge -> HOLD -> DRAIN -> COMMIT -> RESP. Registers update at end of COMMIT; pulse 4 cycles after acceptance.
- decode_hold_o deasserts in the same cycle the new redirect becomes visible, so no decode straddles old and new mappings.
- A request while not in IDLE is not accepted (req_ready_o=0); the requester holds it stable.
- Clearing when no redirect is active is legal and completes with err=0.
- Reset mid-operation returns to IDLE with the redirect disabled; there is no partial commit.

Optional Feature:
- Macro AXI_REDIRECT_LOCK_EN.
- Defined:
  - Adds a sticky lock bit, set by a successful swap commit.
  - While locked, any further request (swap or clear) is rejected: IDLE -> RESP with err=1, no hold asserted.
  - Lock clears only on rst_n.
- Undefined: no lock; redirects may be changed or cleared any number of times.

Decomposition:
- Package axi_redirect_pkg:
  - state enum {IDLE, HOLD, DRAIN, COMMIT, RESP}
  - request struct {clear, source, target}
  - default DRAIN_TIMEOUT constant
- Sub-module axi_redirect_drain_timer: counter with clear, enable and expire output at DRAIN_TIMEOUT-1.
- The FSM, legality check and committed registers stay in the top module.

Test Plan:
- Swap source=2, target=5, all ports idle -> accepted; decode_hold_o high 3 cycles; source_r_o=2, target_r_o=5, redirect_valid_r_o=1; rsp_valid_o=1, rsp_err_o=0 four cycles after acceptance.
- Swap with outstanding_trans_i[3]=1 for 20 cycles -> hold asserted throughout; commit occurs the cycle after the flag drops; err=0.
- outstanding_trans_i stuck at 1, DRAIN_TIMEOUT=16 -> abort after 16 DRAIN cycles; rsp_err_o=1; registers keep their prior values; hold released.
- Request source=4, target=4 -> immediate RESP with err=1; decode_hold_o never asserted.
- Active redirect 1->6, then clear request -> redirect_valid_r_o=0; source_r_o stays 1; err=0. Assert rst_n low during DRAIN of a second request -> all outputs return to reset values.
- AXI_REDIRECT_LOCK_EN defined: swap 0->7 succeeds; subsequent clear -> rsp_err_o=1, redirect_valid_r_o stays 1; after reset, a swap is accepted again.
